// File: rtl/cpu_defs.sv
// Shared constants and types for the P8 fetch stage.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFF;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // REQ: requesting, HOLD: word buffered while D stalls, DRAIN: discarding a pending fetch
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/f_fetch_fsm.sv
// Fetch controller: state register, fault/completion decode, memory request and busy.
module f_fetch_fsm
  import cpu_defs::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc_i,
  input  logic         im_ready_i,
  input  logic         d_stall_i,
  input  logic         req_i,
  output fetch_state_e state_o,
  output logic         fault_o,
  output logic         complete_o,
  output logic         release_o,
  output logic         im_req_o,
  output logic         busy_o
);

  fetch_state_e state_q, state_d;
  logic         pc_bad;

  assign pc_bad = (pc_i[1:0] != 2'b00) || (pc_i < IM_BASE) || (pc_i > IM_LIMIT);

  // State register; asynchronous reset returns to requesting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= REQ;
    else        state_q <= state_d;
  end

  // Decode completion, request/busy outputs and the next state
  always_comb begin
    state_d    = state_q;
    fault_o    = 1'b0;
    complete_o = 1'b0;
    release_o  = 1'b0;
    im_req_o   = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      REQ: begin
        fault_o    = pc_bad;
        complete_o = pc_bad || im_ready_i;
        im_req_o   = !pc_bad;
        busy_o     = !complete_o;
        release_o  = complete_o && !d_stall_i;
        if (req_i)            state_d = complete_o ? REQ : DRAIN;
        else if (complete_o)  state_d = d_stall_i ? HOLD : REQ;
      end
      HOLD: begin
        release_o = !d_stall_i;
        if (req_i || !d_stall_i) state_d = REQ;
      end
      DRAIN: begin
        im_req_o = 1'b1;
        busy_o   = 1'b1;
        if (im_ready_i) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: PC register, skid buffer, drain address and the F/D pipeline register.
module f_fetch_unit
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_newPC,
  input  logic        D_Stall,
  input  logic        D_isJump,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  input  logic        Req,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic        F_busy,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic        D_BD,
  output logic [4:0]  D_ExcCode
);

  fetch_state_e state;
  logic         fault, complete, release_fd;

  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [4:0]  buf_code_q, buf_code_d;
  logic        buf_bd_q, buf_bd_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        d_bd_q, d_bd_d;
  logic [4:0]  d_code_q, d_code_d;

  // Word/code/BD of the fetch currently completing (faults deliver a zero word)
  logic [31:0] fetch_instr;
  logic [4:0]  fetch_code;

  f_fetch_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .pc_i       (pc_q),
    .im_ready_i (im_ready),
    .d_stall_i  (D_Stall),
    .req_i      (Req),
    .state_o    (state),
    .fault_o    (fault),
    .complete_o (complete),
    .release_o  (release_fd),
    .im_req_o   (im_req),
    .busy_o     (F_busy)
  );

  assign fetch_instr = fault ? 32'h0 : im_rdata;
  assign fetch_code  = fault ? EXC_ADEL : EXC_NONE;

  // In DRAIN the abandoned address stays on the bus until memory accepts it
  assign im_addr = (state == DRAIN) ? drain_addr_q : pc_q;

  // Next-state for PC, skid buffer and F/D register; Req beats eret beats normal load
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_code_d   = buf_code_q;
    buf_bd_d     = buf_bd_q;
    d_instr_d    = d_instr_q;
    d_pc_d       = d_pc_q;
    d_valid_d    = d_valid_q;
    d_bd_d       = d_bd_q;
    d_code_d     = d_code_q;

    if (state == REQ && Req && !complete) drain_addr_d = pc_q;

    if (state == REQ && complete && D_Stall && !Req) begin
      buf_instr_d = fetch_instr;
      buf_code_d  = fetch_code;
      buf_bd_d    = D_isJump;
    end

    if (Req || (release_fd && D_eret)) begin
      pc_d      = Req ? EXC_PC : EPC;
      d_instr_d = 32'h0;
      d_valid_d = 1'b0;
      d_bd_d    = 1'b0;
      d_code_d  = EXC_NONE;
    end else if (release_fd) begin
      pc_d      = F_newPC;
      d_pc_d    = pc_q;
      d_valid_d = 1'b1;
      if (state == HOLD) begin
        d_instr_d = buf_instr_q;
        d_code_d  = buf_code_q;
        d_bd_d    = buf_bd_q;
      end else begin
        d_instr_d = fetch_instr;
        d_code_d  = fetch_code;
        d_bd_d    = D_isJump;
      end
    end
  end

  // Register update with asynchronous reset to the power-on fetch state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      buf_instr_q  <= 32'h0;
      buf_code_q   <= EXC_NONE;
      buf_bd_q     <= 1'b0;
      d_instr_q    <= 32'h0;
      d_pc_q       <= 32'h0;
      d_valid_q    <= 1'b0;
      d_bd_q       <= 1'b0;
      d_code_q     <= EXC_NONE;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_instr_q  <= buf_instr_d;
      buf_code_q   <= buf_code_d;
      buf_bd_q     <= buf_bd_d;
      d_instr_q    <= d_instr_d;
      d_pc_q       <= d_pc_d;
      d_valid_q    <= d_valid_d;
      d_bd_q       <= d_bd_d;
      d_code_q     <= d_code_d;
    end
  end

  assign F_PC      = pc_q;
  assign D_Instr   = d_instr_q;
  assign D_PC      = d_pc_q;
  assign D_valid   = d_valid_q;
  assign D_BD      = d_bd_q;
  assign D_ExcCode = d_code_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for the fetch unit: pipeline flow, stalls, faults, flush and eret.
module tb_f_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_newPC;
  logic        D_Stall, D_isJump, D_eret, Req, im_ready;
  logic [31:0] EPC;
  logic        im_req;
  logic [31:0] im_addr, im_rdata, F_PC, D_Instr, D_PC;
  logic        F_busy, D_valid, D_BD;
  logic [4:0]  D_ExcCode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its address scrambled with a fixed pattern
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign im_rdata = mem(im_addr);

  f_fetch_unit dut (
    .clk(clk), .reset(reset), .F_newPC(F_newPC), .D_Stall(D_Stall),
    .D_isJump(D_isJump), .D_eret(D_eret), .EPC(EPC), .Req(Req),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .F_PC(F_PC), .F_busy(F_busy), .D_Instr(D_Instr), .D_PC(D_PC),
    .D_valid(D_valid), .D_BD(D_BD), .D_ExcCode(D_ExcCode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s obs=%h exp=%h", tag, obs, exp);
  endtask

  // Advance one clock: inputs are driven after negedge, outputs read at the next negedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; F_newPC = 32'h0; D_Stall = 0; D_isJump = 0; D_eret = 0;
    EPC = 32'h0; Req = 0; im_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_fpc",   F_PC, 32'h3000);
    chk("rst_dpc",   D_PC, 32'h0);
    chk("rst_dinstr", D_Instr, 32'h0);
    chk("rst_dvalid", {31'b0, D_valid}, 32'h0);
    chk("rst_dexc",  {27'b0, D_ExcCode}, 32'h0);
    reset = 1'b1;

    // Streaming with im_ready held high
    F_newPC = 32'h3004; #1;
    chk("s0_addr", im_addr, 32'h3000);
    chk("s0_req",  {31'b0, im_req}, 32'h1);
    chk("s0_busy", {31'b0, F_busy}, 32'h0);
    step();
    chk("s0_dpc",    D_PC, 32'h3000);
    chk("s0_dinstr", D_Instr, mem(32'h3000));
    chk("s0_dvalid", {31'b0, D_valid}, 32'h1);
    chk("s1_addr",   im_addr, 32'h3004);

    // Memory wait of three cycles at 0x3004
    im_ready = 0; F_newPC = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_addr", im_addr, 32'h3004);
      chk("w_busy", {31'b0, F_busy}, 32'h1);
      step();
      chk("w_dpc",  D_PC, 32'h3000);
    end
    im_ready = 1; #1;
    chk("w_done_busy", {31'b0, F_busy}, 32'h0);
    step();
    chk("w_dpc_after", D_PC, 32'h3004);
    chk("w_dinstr",    D_Instr, mem(32'h3004));
    chk("s2_addr",     im_addr, 32'h3008);

    // Two stalled cycles: completion goes to HOLD, buffered word delivered later
    D_Stall = 1; F_newPC = 32'h300C;
    step();
    chk("h_req",  {31'b0, im_req}, 32'h0);
    chk("h_dpc",  D_PC, 32'h3004);
    chk("h_fpc",  F_PC, 32'h3008);
    step();
    chk("h_req2", {31'b0, im_req}, 32'h0);
    D_Stall = 0; #1;
    chk("h_busy", {31'b0, F_busy}, 32'h0);
    step();
    chk("h_dpc_rel",  D_PC, 32'h3008);
    chk("h_dinstr",   D_Instr, mem(32'h3008));
    chk("h_fpc_rel",  F_PC, 32'h300C);
    chk("h_addr_nxt", im_addr, 32'h300C);

    // Misaligned and out-of-range fetch addresses
    F_newPC = 32'h3002;
    step();
    chk("f1_fpc", F_PC, 32'h3002);
    chk("f1_req", {31'b0, im_req}, 32'h0);
    chk("f1_busy", {31'b0, F_busy}, 32'h0);
    F_newPC = 32'h7000;
    step();
    chk("f1_dexc",   {27'b0, D_ExcCode}, 32'h4);
    chk("f1_dinstr", D_Instr, 32'h0);
    chk("f1_dpc",    D_PC, 32'h3002);
    chk("f2_req",    {31'b0, im_req}, 32'h0);
    F_newPC = 32'h3010;
    step();
    chk("f2_dexc", {27'b0, D_ExcCode}, 32'h4);
    chk("f2_dpc",  D_PC, 32'h7000);

    // Flush while a fetch at 0x3010 is pending: DRAIN keeps the old address
    im_ready = 0; #1;
    chk("d_req0", {31'b0, im_req}, 32'h1);
    chk("d_addr0", im_addr, 32'h3010);
    Req = 1;
    step();
    Req = 0; #1;
    chk("d_fpc",    F_PC, 32'h4180);
    chk("d_addr1",  im_addr, 32'h3010);
    chk("d_busy1",  {31'b0, F_busy}, 32'h1);
    chk("d_dvalid", {31'b0, D_valid}, 32'h0);
    chk("d_dinstr", D_Instr, 32'h0);
    step();
    chk("d_addr2", im_addr, 32'h3010);
    im_ready = 1; F_newPC = 32'h4184; #1;
    chk("d_addr3", im_addr, 32'h3010);
    step();
    chk("d_addr_exc",  im_addr, 32'h4180);
    chk("d_dvalid2",   {31'b0, D_valid}, 32'h0);
    step();
    chk("d_dpc_exc", D_PC, 32'h4180);
    chk("d_dvalid3", {31'b0, D_valid}, 32'h1);

    // Jump in D: the next fetched word is a delay-slot instruction
    D_isJump = 1; F_newPC = 32'h4188;
    step();
    chk("j_dpc", D_PC, 32'h4184);
    chk("j_dbd", {31'b0, D_BD}, 32'h1);

    // eret in D: fetched word discarded, redirect to EPC
    D_isJump = 0; D_eret = 1; EPC = 32'h3020; F_newPC = 32'h418C;
    step();
    D_eret = 0;
    chk("e_dvalid", {31'b0, D_valid}, 32'h0);
    chk("e_dbd",    {31'b0, D_BD}, 32'h0);
    chk("e_dinstr", D_Instr, 32'h0);
    chk("e_addr",   im_addr, 32'h3020);
    F_newPC = 32'h3024;
    step();
    chk("e_dpc",  D_PC, 32'h3020);
    chk("e_dbd2", {31'b0, D_BD}, 32'h0);

    // Flush coinciding with im_ready: no DRAIN, straight to handler
    Req = 1;
    step();
    Req = 0; #1;
    chk("r_addr",   im_addr, 32'h4180);
    chk("r_req",    {31'b0, im_req}, 32'h1);
    chk("r_busy",   {31'b0, F_busy}, 32'h0);
    chk("r_dvalid", {31'b0, D_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
